lif_array: RTL and testbench
============================

// Module: lif_array
// PURPOSE
//  N parallel leaky-integrate-and-fire neurons with a parametrised state width, a selectable leak
//  factor, a runtime-writable shared threshold and a per-neuron refractory period. State advances
//  only on a timestep strobe. It sits between the synaptic current/weight stage and the STDP
//  learning logic, which consumes the registered spike vector.
// PARAMETERS
//  N_NEURONS    4    number of neurons (>=1)
//  WIDTH        8    membrane-state, current and threshold width in bits (>=4)
//  THR_DEFAULT  230  threshold loaded on reset (< 2**WIDTH)
//  REFRAC       2    refractory timesteps after a spike (0 = none); counter is $clog2(REFRAC+1) bits
// PORTS
//  clk        in   1                 clock; all logic on posedge
//  rst_n      in   1                 synchronous active-low reset
//  step_en    in   1                 timestep strobe; neurons update only when it is 1
//  current    in   N_NEURONS*WIDTH   per-neuron input current; neuron i uses bits [i*WIDTH +: WIDTH]
//  leak_sel   in   2                 leak mode (see BEHAVIOUR)
//  thr_wr     in   1                 write strobe for the shared threshold
//  thr_val    in   WIDTH             threshold value written when thr_wr=1
//  spike      out  N_NEURONS         registered spike pulses
//  state      out  N_NEURONS*WIDTH   registered membrane state per neuron
//  refrac     out  N_NEURONS         1 while the neuron's refractory counter is nonzero
// BEHAVIOUR
//  Reset (rst_n=0 at posedge; overrides everything, including mid-refractory):
//   - state=0, spike=0, refrac counters=0, threshold=THR_DEFAULT.
//  step_en=0:
//   - state and counters hold; spike=0, so every spike is a single-cycle pulse.
//  step_en=1, per neuron i:
//   - if refrac_cnt!=0: state<=0, refrac_cnt<=refrac_cnt-1, spike<=0 (current ignored).
//   - otherwise: sum = current_i + leak(state_i), computed in WIDTH+1 bits and saturated to 2**WIDTH-1.
//     - if sum >= thr_eff: spike<=1, state<=0, refrac_cnt<=REFRAC.
//     - else: state<=sum, spike<=0.
//  leak(s), right shifts truncating:
//   - 0: s>>1
//   - 1: (s>>1)+(s>>2)
//   - 2: (s>>1)+(s>>2)+(s>>3)
//   - 3: s (pure integrator)
//  Threshold:
//   - thr_wr=1 loads thr_val at the posedge and applies from the next cycle.
//   - If thr_wr and step_en are both 1 in a cycle, that update uses the old threshold.
//  Timing:
//   - spike, state and refrac are all registered; latency is 1 clk from the step_en edge.
//   - No wrap-around anywhere: state saturates and never exceeds 2**WIDTH-1.
//   - Threshold 0: a non-refractory neuron fires on every step.
// CONFIGURATION
//  LIF_ADAPTIVE_THR_EN defined: adds a per-neuron WIDTH-bit offset, reset to 0.
//   - thr_eff = threshold + offset, saturated to 2**WIDTH-1.
//   - On spike: offset += 2**(WIDTH-3), saturating.
//   - On any other step_en cycle: offset -= offset>>2.
//  LIF_ADAPTIVE_THR_EN undefined: thr_eff = threshold; no offset registers exist.
// STRUCTURE
//  lif_pkg:
//   - leak-mode localparams LEAK_HALF, LEAK_3Q, LEAK_7_8, LEAK_NONE.
//   - a function sat_add(a,b,width).
//  Sub-module lif_cell: one neuron (state, refractory counter, optional offset) taking shared
//   threshold/leak_sel; lif_array generates N_NEURONS instances and holds the threshold register.
// TESTING  (N_NEURONS=4, WIDTH=8, THR_DEFAULT=230, REFRAC=2)
//  1. Reset: rst_n=0 for 2 clk -> state=0, spike=0, refrac=0; threshold reads back as 230 (spike test).
//  2. Integration, leak_sel=2, current=100, step_en every clk -> state 100, 187, then a spike with state 0
//     (sum 262 saturates to 255, which is >=230).
//  3. Refractory, current=255 after a spike -> next 2 steps: state=0, spike=0, refrac=1; 3rd step spikes again.
//  4. Hold: step_en=0 for 5 clk with state=150 -> state stays 150, spike=0 throughout.
//  5. Threshold write, thr_wr=1, thr_val=50 with step_en=1, state=0, current=60 -> no spike, state=60;
//     next step (60+45+0... with leak_sel=2 => 60+52=112>=50) -> spike.
//  6. Reset mid-refractory: assert rst_n=0 while refrac=1 -> next clk refrac=0, state=0, threshold=230.
//   With LIF_ADAPTIVE_THR_EN, additionally check the offset steps 0 -> 32 after one spike.

Source files
------------

// File: rtl/lif_pkg.sv
// ============================================================================
// lif_pkg : leak-mode encodings and saturating add shared by the LIF array.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lif_pkg;

    localparam logic [1:0] LEAK_HALF = 2'd0;
    localparam logic [1:0] LEAK_3Q   = 2'd1;
    localparam logic [1:0] LEAK_7_8  = 2'd2;
    localparam logic [1:0] LEAK_NONE = 2'd3;

    // Unsigned add clamped to 2**width-1; callers keep the low width bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          width);
        logic [32:0] s;
        logic [32:0] m;
        s = {1'b0, a} + {1'b0, b};
        m = (33'd1 << width) - 33'd1;
        return (s > m) ? m[31:0] : s[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/lif_cell.sv
// ============================================================================
// lif_cell : one leaky-integrate-and-fire neuron with refractory counter.
// LIF_ADAPTIVE_THR_EN adds a per-neuron adaptive threshold offset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lif_cell
    import lif_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int REFRAC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_step_en,
    input  logic [WIDTH-1:0] i_current,
    input  logic [WIDTH-1:0] i_thr,
    input  logic [1:0]       i_leak_sel,
    output logic             o_spike,
    output logic [WIDTH-1:0] o_state,
    output logic             o_refrac
);

    localparam int             CNT_W    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [CNT_W-1:0] C_REFRAC = CNT_W'(REFRAC);

    logic [WIDTH-1:0] r_state;
    logic             r_spike;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_leak;
    logic [31:0]      w_sum_full;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_thr_eff;
    logic             w_fire;
    logic             w_unused_bits;

    always_comb begin
        w_leak = r_state;
        case (i_leak_sel)
            LEAK_HALF: w_leak = r_state >> 1;
            LEAK_3Q:   w_leak = (r_state >> 1) + (r_state >> 2);
            LEAK_7_8:  w_leak = (r_state >> 1) + (r_state >> 2) + (r_state >> 3);
            default:   w_leak = r_state;
        endcase
    end

    assign w_sum_full = sat_add(32'(i_current), 32'(w_leak), WIDTH);
    assign w_sum      = w_sum_full[WIDTH-1:0];

`ifdef LIF_ADAPTIVE_THR_EN
    logic [WIDTH-1:0] r_offset;
    logic [31:0]      w_thr_full;
    logic [31:0]      w_inc_full;

    assign w_thr_full    = sat_add(32'(i_thr), 32'(r_offset), WIDTH);
    assign w_inc_full    = sat_add(32'(r_offset), 32'(1) << (WIDTH - 3), WIDTH);
    assign w_thr_eff     = w_thr_full[WIDTH-1:0];
    assign w_unused_bits = ^{w_sum_full[31:WIDTH], w_thr_full[31:WIDTH], w_inc_full[31:WIDTH]};

    // Offset grows on a spike and decays by a quarter on every other step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_offset <= '0;
        end else if (i_step_en) begin
            if (w_fire) r_offset <= w_inc_full[WIDTH-1:0];
            else        r_offset <= r_offset - (r_offset >> 2);
        end
    end
`else
    assign w_thr_eff     = i_thr;
    assign w_unused_bits = ^w_sum_full[31:WIDTH];
`endif

    assign w_fire = (r_cnt == '0) && (w_sum >= w_thr_eff);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= '0;
            r_spike <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_spike <= 1'b0;
            if (i_step_en) begin
                if (r_cnt != '0) begin
                    r_state <= '0;
                    r_cnt   <= r_cnt - CNT_W'(1);
                end else if (w_fire) begin
                    r_spike <= 1'b1;
                    r_state <= '0;
                    r_cnt   <= C_REFRAC;
                end else begin
                    r_state <= w_sum;
                end
            end
        end
    end

    assign o_spike  = r_spike;
    assign o_state  = r_state;
    assign o_refrac = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/lif_array.sv
// ============================================================================
// lif_array : N parallel LIF neurons sharing a runtime-writable threshold.
// LIF_ADAPTIVE_THR_EN (in lif_cell) enables per-neuron adaptive offsets.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lif_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS   = 4,
    parameter int WIDTH       = 8,
    parameter int THR_DEFAULT = 230,
    parameter int REFRAC      = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       step_en,
    input  logic [N_NEURONS*WIDTH-1:0] current,
    input  logic [1:0]                 leak_sel,
    input  logic                       thr_wr,
    input  logic [WIDTH-1:0]           thr_val,
    output logic [N_NEURONS-1:0]       spike,
    output logic [N_NEURONS*WIDTH-1:0] state,
    output logic [N_NEURONS-1:0]       refrac
);

    logic [WIDTH-1:0] r_thr;

    // A write in the same cycle as a step lands after that step has used the old value.
    always_ff @(posedge clk) begin
        if (!rst_n)      r_thr <= WIDTH'(THR_DEFAULT);
        else if (thr_wr) r_thr <= thr_val;
    end

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_cell
        lif_cell #(
            .WIDTH  (WIDTH),
            .REFRAC (REFRAC)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_step_en  (step_en),
            .i_current  (current[i*WIDTH +: WIDTH]),
            .i_thr      (r_thr),
            .i_leak_sel (leak_sel),
            .o_spike    (spike[i]),
            .o_state    (state[i*WIDTH +: WIDTH]),
            .o_refrac   (refrac[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_lif_array.sv
// ============================================================================
// tb_lif_array : directed scoreboard bench for lif_array (4 x 8-bit neurons).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lif_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_en = 1'b0;
    logic [31:0] current = '0;
    logic [1:0]  leak_sel = 2'd0;
    logic        thr_wr = 1'b0;
    logic [7:0]  thr_val = '0;
    logic [3:0]  spike;
    logic [31:0] state;
    logic [3:0]  refrac;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] st;
        logic [3:0]  sp;
        logic [3:0]  rf;
    } exp_t;
    exp_t q[$];

    int m_state[4];
    int m_cnt[4];
    int m_off[4];
    int m_thr;

    lif_array #(
        .N_NEURONS   (4),
        .WIDTH       (8),
        .THR_DEFAULT (230),
        .REFRAC      (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_en  (step_en),
        .current  (current),
        .leak_sel (leak_sel),
        .thr_wr   (thr_wr),
        .thr_val  (thr_val),
        .spike    (spike),
        .state    (state),
        .refrac   (refrac)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic int leak_f(input int s, input logic [1:0] m);
        case (m)
            2'd0:    return s >> 1;
            2'd1:    return (s >> 1) + (s >> 2);
            2'd2:    return (s >> 1) + (s >> 2) + (s >> 3);
            default: return s;
        endcase
    endfunction

    function automatic logic [31:0] cur4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare after the edge.
    task automatic drive(input logic rn, input logic se, input logic [31:0] cur,
                         input logic [1:0] ls, input logic tw, input logic [7:0] tv);
        exp_t e;
        int   sum, te;
        rst_n = rn; step_en = se; current = cur; leak_sel = ls; thr_wr = tw; thr_val = tv;
        e.sp = '0;
        if (!rn) begin
            for (int i = 0; i < 4; i++) begin
                m_state[i] = 0; m_cnt[i] = 0; m_off[i] = 0;
            end
            m_thr = 230;
        end else begin
            if (se) begin
                for (int i = 0; i < 4; i++) begin
                    sum = int'(cur[i*8 +: 8]) + leak_f(m_state[i], ls);
                    if (sum > 255) sum = 255;
                    te = m_thr;
`ifdef LIF_ADAPTIVE_THR_EN
                    te = te + m_off[i];
                    if (te > 255) te = 255;
`endif
                    if (m_cnt[i] != 0) begin
                        m_state[i] = 0;
                        m_cnt[i]   = m_cnt[i] - 1;
                        m_off[i]   = m_off[i] - (m_off[i] >> 2);
                    end else if (sum >= te) begin
                        e.sp[i]    = 1'b1;
                        m_state[i] = 0;
                        m_cnt[i]   = 2;
                        m_off[i]   = (m_off[i] + 32 > 255) ? 255 : m_off[i] + 32;
                    end else begin
                        m_state[i] = sum;
                        m_off[i]   = m_off[i] - (m_off[i] >> 2);
                    end
                end
            end
            if (tw) m_thr = int'(tv);
        end
        for (int i = 0; i < 4; i++) begin
            e.st[i*8 +: 8] = 8'(m_state[i]);
            e.rf[i]        = (m_cnt[i] != 0);
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("state_vec", state, e.st);
        chk("spike_vec", {28'd0, spike}, {28'd0, e.sp});
        chk("refrac_vec", {28'd0, refrac}, {28'd0, e.rf});
    endtask

    initial begin
        logic [31:0] c;
        // Reset
        drive(0, 0, 0, 2, 0, 0);
        drive(0, 0, 0, 2, 0, 0);
        chk("reset_state", state, 32'd0);
        chk("reset_spike", {28'd0, spike}, 32'd0);
        chk("reset_refrac", {28'd0, refrac}, 32'd0);

        // Integration with 7/8 leak
        c = cur4(100, 10, 0, 255);
        drive(1, 1, c, 2, 0, 0);
        chk("int_s1_n0", {24'd0, state[7:0]}, 32'd100);
        chk("int_s1_n3_spike", {31'd0, spike[3]}, 32'd1);
`ifdef LIF_ADAPTIVE_THR_EN
        chk("offset_after_spike", {24'd0, dut.g_cell[3].u_cell.r_offset}, 32'd32);
`endif
        drive(1, 1, c, 2, 0, 0);
        chk("int_s2_n0", {24'd0, state[7:0]}, 32'd187);
        drive(1, 1, c, 2, 0, 0);
        chk("int_s3_n0_spike", {31'd0, spike[0]}, 32'd1);
        chk("int_s3_n0_state", {24'd0, state[7:0]}, 32'd0);

        // Refractory window
        c = cur4(255, 10, 0, 255);
        drive(1, 1, c, 2, 0, 0);
        chk("ref_s1_n0_refrac", {31'd0, refrac[0]}, 32'd1);
        chk("ref_s1_n0_spike", {31'd0, spike[0]}, 32'd0);
        drive(1, 1, c, 2, 0, 0);
        chk("ref_s2_n0_state", {24'd0, state[7:0]}, 32'd0);
        chk("ref_s2_n0_spike", {31'd0, spike[0]}, 32'd0);
        drive(1, 1, c, 2, 0, 0);
        chk("ref_s3_n0_spike", {31'd0, spike[0]}, 32'd1);

        // Hold with step_en low
        drive(1, 1, 0, 2, 0, 0);
        drive(1, 1, 0, 2, 0, 0);
        drive(1, 1, cur4(150, 0, 0, 0), 3, 0, 0);
        chk("hold_load_n0", {24'd0, state[7:0]}, 32'd150);
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, cur4(200, 200, 200, 200), 3, 0, 0);
            chk("hold_n0_state", {24'd0, state[7:0]}, 32'd150);
            chk("hold_spike", {28'd0, spike}, 32'd0);
        end

        // Threshold write coincident with a step uses the old threshold
        drive(0, 0, 0, 2, 0, 0);
        c = cur4(60, 20, 60, 0);
        drive(1, 1, c, 2, 1, 50);
        chk("thr_s1_n0_state", {24'd0, state[7:0]}, 32'd60);
        chk("thr_s1_n0_spike", {31'd0, spike[0]}, 32'd0);
        drive(1, 1, c, 2, 0, 0);
        chk("thr_s2_n0_spike", {31'd0, spike[0]}, 32'd1);

        // Threshold zero: every non-refractory neuron fires
        drive(1, 1, 0, 3, 1, 0);
        drive(1, 1, 0, 3, 0, 0);
        chk("thr0_n1_spike", {31'd0, spike[1]}, 32'd1);
        chk("thr0_n3_spike", {31'd0, spike[3]}, 32'd1);

        // Reset while refractory restores defaults
        drive(0, 0, 0, 2, 0, 0);
        chk("rst_mid_refrac", {28'd0, refrac}, 32'd0);
        chk("rst_mid_state", state, 32'd0);
        drive(1, 1, cur4(230, 229, 0, 0), 2, 0, 0);
        chk("thr_default_eq", {28'd0, spike}, 32'd1);

        // Other leak modes
        drive(1, 1, cur4(0, 0, 100, 0), 0, 0, 0);
        drive(1, 1, cur4(0, 0, 100, 0), 1, 0, 0);
        chk("leak_3q_n2", {24'd0, state[23:16]}, 32'd175);
        drive(1, 1, cur4(255, 255, 255, 255), 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
